// File: rtl/gemm_tile_scheduler_pkg.sv
// Shared types, default widths and helpers for the GEMM tile scheduler.
package gemm_tile_scheduler_pkg;

  localparam int unsigned AddrWidthDef     = 12;
  localparam int unsigned SizeAddrWidthDef = 32;
  localparam int unsigned RowParDef        = 4;
  localparam int unsigned ColParDef        = 16;
  localparam int unsigned DrainCycles      = 2;
  localparam int unsigned DrainCntWidth    = $clog2(DrainCycles);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  // Overflow-safe ceiling division (no num+den-1 term).
  function automatic logic [SizeAddrWidthDef-1:0] ceil_div(
    input logic [SizeAddrWidthDef-1:0] num,
    input logic [SizeAddrWidthDef-1:0] den
  );
    return num / den + SizeAddrWidthDef'(num % den != '0);
  endfunction

endpackage

// File: rtl/gemm_tile_scheduler_if.sv
// Control/SRAM/MAC bundle between the top-level controller and the tile scheduler.
interface gemm_tile_scheduler_if
  import gemm_tile_scheduler_pkg::*;
#(
  parameter int unsigned AddrWidth     = AddrWidthDef,
  parameter int unsigned SizeAddrWidth = SizeAddrWidthDef,
  parameter int unsigned RowPar        = RowParDef,
  parameter int unsigned ColPar        = ColParDef
);

  logic                     start_i;
  logic [SizeAddrWidth-1:0] M_size_i;
  logic [SizeAddrWidth-1:0] K_size_i;
  logic [SizeAddrWidth-1:0] N_size_i;
  logic [AddrWidth-1:0]     sram_a_addr_o;
  logic [AddrWidth-1:0]     sram_b_addr_o;
  logic [AddrWidth-1:0]     sram_c_addr_o;
  logic                     sram_c_we_o;
  logic                     mac_valid_o;
  logic                     mac_clr_o;
  logic [RowPar-1:0]        mac_row_en_o;
  logic [ColPar-1:0]        mac_col_en_o;
  logic                     busy_o;
  logic                     done_o;

  modport master (
    output start_i, M_size_i, K_size_i, N_size_i,
    input  sram_a_addr_o, sram_b_addr_o, sram_c_addr_o, sram_c_we_o,
    input  mac_valid_o, mac_clr_o, mac_row_en_o, mac_col_en_o, busy_o, done_o
  );

  modport slave (
    input  start_i, M_size_i, K_size_i, N_size_i,
    output sram_a_addr_o, sram_b_addr_o, sram_c_addr_o, sram_c_we_o,
    output mac_valid_o, mac_clr_o, mac_row_en_o, mac_col_en_o, busy_o, done_o
  );

endinterface

// File: rtl/gemm_tile_scheduler_loop_counter.sv
// Loop index counter: clears on load, steps on enable, wraps to 0 after limit-1.
module gemm_tile_scheduler_loop_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [Width-1:0] limit_i,
  output logic [Width-1:0] count_o,
  output logic             last_c
);

  assign last_c = (count_o == limit_i - Width'(1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_o <= '0;
    end else if (load_i) begin
      count_o <= '0;
    end else if (en_i) begin
      count_o <= last_c ? '0 : count_o + Width'(1);
    end
  end

endmodule

// File: rtl/gemm_tile_scheduler.sv
// Tile loop-nest sequencer for the output-stationary GEMM MAC array:
// mt outer, nt middle, k inner; one A/B read pair per cycle, C write per tile.
module gemm_tile_scheduler
  import gemm_tile_scheduler_pkg::*;
#(
  parameter int unsigned AddrWidth     = AddrWidthDef,
  parameter int unsigned SizeAddrWidth = SizeAddrWidthDef,
  parameter int unsigned RowPar        = RowParDef,
  parameter int unsigned ColPar        = ColParDef
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  gemm_tile_scheduler_if.slave bus
);

  localparam int unsigned SW = SizeAddrWidth;

  state_e                   state_q, state_d;
  logic [SW-1:0]            m_q, n_q, k_lim_q, nt_lim_q, mt_lim_q;
  logic [SW-1:0]            k_cnt, nt_cnt, mt_cnt;
  logic                     k_last, nt_last, mt_last;
  logic [SW-1:0]            row_rem_c, col_rem_c;
  logic [RowPar-1:0]        row_en_c;
  logic [ColPar-1:0]        col_en_c;
  logic [AddrWidth-1:0]     a_base_q, b_base_q, c_idx_q, c_addr_p_q, k_step_c;
  logic [DrainCntWidth-1:0] drain_q;
  logic                     we_p_q;
  logic                     accept_c, sizes_ok_c, load_c, run_c, nt_en_c, mt_en_c, all_last_c;

  gemm_tile_scheduler_loop_counter #(.Width(SW)) u_k_cnt (
    .clk_i, .rst_ni, .load_i(load_c), .en_i(run_c),
    .limit_i(k_lim_q), .count_o(k_cnt), .last_c(k_last)
  );

  gemm_tile_scheduler_loop_counter #(.Width(SW)) u_nt_cnt (
    .clk_i, .rst_ni, .load_i(load_c), .en_i(nt_en_c),
    .limit_i(nt_lim_q), .count_o(nt_cnt), .last_c(nt_last)
  );

  gemm_tile_scheduler_loop_counter #(.Width(SW)) u_mt_cnt (
    .clk_i, .rst_ni, .load_i(load_c), .en_i(mt_en_c),
    .limit_i(mt_lim_q), .count_o(mt_cnt), .last_c(mt_last)
  );

  // Next state, loop chaining and ragged-edge masks for the pair issued this cycle.
  always_comb begin
    state_d    = state_q;
    accept_c   = (state_q == IDLE) && bus.start_i;
    sizes_ok_c = (bus.M_size_i != '0) && (bus.K_size_i != '0) && (bus.N_size_i != '0);
    load_c     = accept_c && sizes_ok_c;
    run_c      = (state_q == RUN);
    nt_en_c    = run_c && k_last;
    mt_en_c    = nt_en_c && nt_last;
    all_last_c = k_last && nt_last && mt_last;
    k_step_c   = AddrWidth'(k_lim_q);
    row_rem_c  = m_q - SW'(mt_cnt * RowPar);
    col_rem_c  = n_q - SW'(nt_cnt * ColPar);
    row_en_c   = '0;
    col_en_c   = '0;
    for (int unsigned r = 0; r < RowPar; r++) row_en_c[r] = SW'(r) < row_rem_c;
    for (int unsigned c = 0; c < ColPar; c++) col_en_c[c] = SW'(c) < col_rem_c;

    unique case (state_q)
      IDLE:    if (accept_c) state_d = sizes_ok_c ? RUN : DONE;
      RUN:     if (all_last_c) state_d = DRAIN;
      DRAIN:   if (drain_q == DrainCntWidth'(DrainCycles - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q            <= IDLE;
      drain_q            <= '0;
      m_q                <= '0;
      n_q                <= '0;
      k_lim_q            <= '0;
      nt_lim_q           <= '0;
      mt_lim_q           <= '0;
      a_base_q           <= '0;
      b_base_q           <= '0;
      c_idx_q            <= '0;
      c_addr_p_q         <= '0;
      we_p_q             <= 1'b0;
      bus.sram_a_addr_o  <= '0;
      bus.sram_b_addr_o  <= '0;
      bus.sram_c_addr_o  <= '0;
      bus.sram_c_we_o    <= 1'b0;
      bus.mac_valid_o    <= 1'b0;
      bus.mac_clr_o      <= 1'b0;
      bus.mac_row_en_o   <= '0;
      bus.mac_col_en_o   <= '0;
      bus.busy_o         <= 1'b0;
      bus.done_o         <= 1'b0;
    end else begin
      state_q    <= state_d;
      bus.busy_o <= (state_d == RUN) || (state_d == DRAIN);
      bus.done_o <= (state_d == DONE);
      drain_q    <= (state_q == DRAIN && state_d == DRAIN) ? drain_q + DrainCntWidth'(1) : '0;

      // Address walk: A base steps by K per mt, B base by K per nt, k adds 1.
      if (load_c) begin
        m_q               <= bus.M_size_i;
        n_q               <= bus.N_size_i;
        k_lim_q           <= bus.K_size_i;
        mt_lim_q          <= SW'(ceil_div(SizeAddrWidthDef'(bus.M_size_i), SizeAddrWidthDef'(RowPar)));
        nt_lim_q          <= SW'(ceil_div(SizeAddrWidthDef'(bus.N_size_i), SizeAddrWidthDef'(ColPar)));
        a_base_q          <= '0;
        b_base_q          <= '0;
        c_idx_q           <= '0;
        bus.sram_a_addr_o <= '0;
        bus.sram_b_addr_o <= '0;
      end else if (run_c && !all_last_c) begin
        if (!k_last) begin
          bus.sram_a_addr_o <= bus.sram_a_addr_o + AddrWidth'(1);
          bus.sram_b_addr_o <= bus.sram_b_addr_o + AddrWidth'(1);
        end else if (!nt_last) begin
          b_base_q          <= b_base_q + k_step_c;
          bus.sram_b_addr_o <= b_base_q + k_step_c;
          bus.sram_a_addr_o <= a_base_q;
        end else begin
          a_base_q          <= a_base_q + k_step_c;
          bus.sram_a_addr_o <= a_base_q + k_step_c;
          b_base_q          <= '0;
          bus.sram_b_addr_o <= '0;
        end
        if (k_last) c_idx_q <= c_idx_q + AddrWidth'(1);
      end

      // Stage 1: flags aligned with SRAM read data.
      bus.mac_valid_o  <= run_c;
      bus.mac_clr_o    <= run_c && (k_cnt == '0);
      bus.mac_row_en_o <= run_c ? row_en_c : '0;
      bus.mac_col_en_o <= run_c ? col_en_c : '0;
      we_p_q           <= run_c && k_last;
      if (run_c && k_last) c_addr_p_q <= c_idx_q;

      // Stage 2: accumulators registered, write the finished tile.
      bus.sram_c_we_o <= we_p_q;
      if (we_p_q) bus.sram_c_addr_o <= c_addr_p_q;
    end
  end

endmodule

// File: tb/tb_gemm_tile_scheduler.sv
// Self-checking bench: directed tile-schedule scenarios plus random sizes against a loop-nest model.
module tb_gemm_tile_scheduler;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Expected held values of the address outputs, carried across runs.
  logic [11:0] exp_a = '0;
  logic [11:0] exp_b = '0;
  logic [11:0] exp_c = '0;

  gemm_tile_scheduler_if bus ();

  gemm_tile_scheduler dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One scheduling run; cycle 0 is the cycle in which start_i is presented.
  task automatic run(input int m, input int k, input int n, input bit hold,
                     input int rst_at, input string name);
    int mt_n, nt_n, tt, i, kk, tile, mtc, ntc;
    bit zero, v, clr, we, busy, done;
    logic [3:0]  re;
    logic [15:0] ce;
    zero = (m == 0) || (k == 0) || (n == 0);
    mt_n = (m + 3) / 4;
    nt_n = (n + 15) / 16;
    tt   = zero ? 0 : mt_n * nt_n * k;
    for (int t = 0; t <= tt + 5; t++) begin
      @(negedge clk_i);
      v = 0; clr = 0; we = 0; re = '0; ce = '0;
      busy = !zero && (t >= 1) && (t <= tt + 2);
      done = zero ? (t == 1) : (t == tt + 3);
      if (rst_at >= 0 && t > rst_at) begin
        exp_a = '0; exp_b = '0; exp_c = '0; busy = 0; done = 0;
      end else begin
        if (t >= 1 && t <= tt) begin
          i = t - 1; kk = i % k; tile = i / k; ntc = tile % nt_n; mtc = tile / nt_n;
          exp_a = 12'(mtc * k + kk);
          exp_b = 12'(ntc * k + kk);
        end
        if (t >= 2 && t <= tt + 1) begin
          i = t - 2; kk = i % k; tile = i / k; ntc = tile % nt_n; mtc = tile / nt_n;
          v = 1; clr = (kk == 0);
          for (int r = 0; r < 4; r++) re[r] = (mtc * 4 + r) < m;
          for (int c = 0; c < 16; c++) ce[c] = (ntc * 16 + c) < n;
        end
        if (t >= 3 && t <= tt + 2) begin
          i = t - 3; tile = i / k; ntc = tile % nt_n; mtc = tile / nt_n;
          if (i % k == k - 1) begin
            we = 1;
            exp_c = 12'(mtc * nt_n + ntc);
          end
        end
      end
      chk($sformatf("%s.a_addr@%0d", name, t), 32'(bus.sram_a_addr_o), 32'(exp_a));
      chk($sformatf("%s.b_addr@%0d", name, t), 32'(bus.sram_b_addr_o), 32'(exp_b));
      chk($sformatf("%s.c_addr@%0d", name, t), 32'(bus.sram_c_addr_o), 32'(exp_c));
      chk($sformatf("%s.c_we@%0d", name, t),   32'(bus.sram_c_we_o),   32'(we));
      chk($sformatf("%s.valid@%0d", name, t),  32'(bus.mac_valid_o),   32'(v));
      chk($sformatf("%s.clr@%0d", name, t),    32'(bus.mac_clr_o),     32'(clr));
      chk($sformatf("%s.row_en@%0d", name, t), 32'(bus.mac_row_en_o),  32'(re));
      chk($sformatf("%s.col_en@%0d", name, t), 32'(bus.mac_col_en_o),  32'(ce));
      chk($sformatf("%s.busy@%0d", name, t),   32'(bus.busy_o),        32'(busy));
      chk($sformatf("%s.done@%0d", name, t),   32'(bus.done_o),        32'(done));
      // Drive inputs for the remainder of cycle t.
      if (t == 0) begin
        bus.start_i  = 1'b1;
        bus.M_size_i = 32'(m);
        bus.K_size_i = 32'(k);
        bus.N_size_i = 32'(n);
      end else begin
        bus.start_i = hold && (t < tt + 3);
        if (!hold || t == 10) begin
          bus.M_size_i = 32'($urandom_range(1, 40));
          bus.K_size_i = 32'($urandom_range(1, 40));
          bus.N_size_i = 32'($urandom_range(1, 80));
        end
      end
      rst_ni = !(t == rst_at);
    end
    bus.start_i = 1'b0;
  endtask

  initial begin
    int m, k, n;
    bus.start_i  = 1'b0;
    bus.M_size_i = '0;
    bus.K_size_i = '0;
    bus.N_size_i = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset.a_addr", 32'(bus.sram_a_addr_o), 32'd0);
    chk("reset.c_we",   32'(bus.sram_c_we_o),   32'd0);
    chk("reset.valid",  32'(bus.mac_valid_o),   32'd0);
    chk("reset.row_en", 32'(bus.mac_row_en_o),  32'd0);
    chk("reset.busy",   32'(bus.busy_o),        32'd0);
    chk("reset.done",   32'(bus.done_o),        32'd0);
    rst_ni = 1'b1;

    run(4, 64, 16, 1'b0, -1, "t1_single_tile");
    run(8, 3, 32, 1'b0, -1, "t2_2x2");
    run(5, 2, 17, 1'b0, -1, "t3_ragged");
    run(4, 0, 16, 1'b0, -1, "t4_k_zero");
    run(4, 64, 16, 1'b1, -1, "t5_start_held");
    run(8, 3, 32, 1'b0, 7, "t6_reset_abort");
    run(8, 3, 32, 1'b0, -1, "t6_rerun");

    for (int j = 0; j < 16; j++) begin
      m = $urandom_range(0, 12);
      k = $urandom_range(0, 6);
      n = $urandom_range(0, 40);
      if (j % 4 != 0) begin
        if (m == 0) m = 1;
        if (k == 0) k = 1;
        if (n == 0) n = 1;
      end
      run(m, k, n, 1'b0, -1, $sformatf("rnd%0d_m%0d_k%0d_n%0d", j, m, k, n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
